data_path_arbiter: RTL and testbench

Parametrised successor to the fixed 2:1 IO / MMIO / ALU-CC selection chain. Merges `CHANNELS` independent `WIDTH`-bit source channels onto one registered output using a valid/ready handshake and a one-entry output buffer. Arbitration is fixed-priority by default, or round-robin when the configuration macro is defined. The block sits between the datapath sources (IO memory, MMIO, ALU/condition codes, UART receive) and the register-file write port.

---
 rtl/data_path_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_data_path_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_path_arbiter.sv
// -----------------------------------------------------------------------------
// data_path_arbiter
//
// Merges CHANNELS independent WIDTH-bit source channels onto one registered
// output through a one-entry output buffer with valid/ready handshakes on
// both sides. The buffer can be drained and reloaded in the same cycle, so
// the output can carry one word per cycle.
//
// Arbitration:
//   default                      fixed priority, channel 0 highest
//   DATA_PATH_ARBITER_RR_EN      round-robin, search starts at a pointer that
//                                moves to (winner + 1) after every transfer
//
// Parameters:
//   WIDTH     data width per channel
//   CHANNELS  number of source channels (2..16)
//   IDXW      channel index width, equal to ceil(log2(CHANNELS))
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   per-channel request
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   per-channel accept, one-hot or zero (combinational)
//   out_valid  output buffer holds a word (registered)
//   out_data   buffered word (registered)
//   out_sel    index of the channel that supplied out_data (registered)
//   out_ready  consumer accepts the buffered word
// -----------------------------------------------------------------------------
module data_path_arbiter #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int IDXW     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [IDXW-1:0]           out_sel,
    input  logic                      out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [WIDTH-1:0]  out_data_reg;
    logic [IDXW-1:0]   out_sel_reg;

    logic [WIDTH-1:0]  chan_data [CHANNELS];

    logic              drain;
    logic              load_open;
    logic              grant_found;
    logic [IDXW-1:0]   grant_idx;
    logic              transfer;

    // Unpack the flat data bus into one word per channel.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign out_valid = (state_reg == FULL);
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

    // The buffer can take a new word when it is empty or being drained now.
    assign drain     = out_valid & out_ready;
    assign load_open = ~out_valid | drain;

`ifdef DATA_PATH_ARBITER_RR_EN
    logic [IDXW-1:0] ptr_reg;
    logic [IDXW-1:0] ptr_next;

    // First requester at or after the pointer, wrapping modulo CHANNELS.
    // The loop runs from the far end so the nearest candidate is written last.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            cand = int'(ptr_reg) + k;
            if (cand >= CHANNELS) begin
                cand = cand - CHANNELS;
            end
            if (in_valid[IDXW'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IDXW'(cand);
            end
        end
    end

    // Pointer moves only on a transfer, to the channel after the winner.
    always_comb begin
        ptr_next = ptr_reg;
        if (transfer) begin
            if (grant_idx == IDXW'(CHANNELS - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`else
    // Lowest-index requester wins; scanning downward leaves it written last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (in_valid[IDXW'(i)]) begin
                grant_found = 1'b1;
                grant_idx   = IDXW'(i);
            end
        end
    end
`endif

    // Grant is one-hot inside the load window. It is held at zero during
    // reset so no source sees an accept that the buffer will not record.
    always_comb begin
        in_ready = '0;
        if (load_open && grant_found && !rst) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign transfer = |(in_valid & in_ready);

    // Next-state logic for the one-entry buffer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: begin
                if (transfer) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (drain && !transfer) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Data and index hold their last values when the buffer drains empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_reg <= '0;
            out_sel_reg  <= '0;
        end else if (transfer) begin
            out_data_reg <= chan_data[grant_idx];
            out_sel_reg  <= grant_idx;
        end
    end

endmodule

// File: tb/tb_data_path_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_path_arbiter
//
// Self-checking bench for data_path_arbiter (WIDTH=16, CHANNELS=4). A small
// reference model tracks buffer occupancy and, in round-robin builds, the
// search pointer. Each accepted word is pushed to a scoreboard queue when
// the bench drives the winning request, and popped when the consumer drains
// the output. Works in both arbitration modes (DATA_PATH_ARBITER_RR_EN).
// -----------------------------------------------------------------------------
module tb_data_path_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    logic [3:0]  pend;
    logic [15:0] d [4];

    int          checks = 0;
    int          errors = 0;
    logic        m_valid = 1'b0;
    int          m_ptr = 0;
    logic [17:0] q [$];

    assign in_valid = pend;
    assign in_data  = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    data_path_arbiter #(
        .WIDTH    (16),
        .CHANNELS (4),
        .IDXW     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    function automatic int model_grant(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // One clock cycle. Called at posedge+1 with inputs already driven.
    task automatic cycle();
        int          g;
        logic [3:0]  exp_ready;
        logic [17:0] e;
        @(negedge clk);
`ifdef DATA_PATH_ARBITER_RR_EN
        g = model_grant(pend, m_ptr);
`else
        g = model_grant(pend, 0);
`endif
        exp_ready = 4'b0000;
        if ((!m_valid || out_ready) && g >= 0) exp_ready = 4'(1 << g);

        checks++;
        if (out_valid !== m_valid) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b at %0t", out_valid, m_valid, $time);
        end
        checks++;
        if (in_ready !== exp_ready) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b (in_valid %b) at %0t",
                     in_ready, exp_ready, pend, $time);
        end
        if (m_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: drain with empty queue at %0t", $time);
            end else begin
                e = q.pop_front();
                if ({out_sel, out_data} !== e) begin
                    errors++;
                    $display("FAIL out_word: got sel %0d data %h expected sel %0d data %h at %0t",
                             out_sel, out_data, e[17:16], e[15:0], $time);
                end else begin
                    $display("drain sel %0d data %h", out_sel, out_data);
                end
            end
        end
        if (exp_ready != 4'b0000) begin
            q.push_back({2'(g), d[g]});
            m_ptr = (g + 1) % 4;
        end
        m_valid = (exp_ready != 4'b0000) || (m_valid && !out_ready);
        @(posedge clk);
        #1;
        pend = pend & ~exp_ready;
    endtask

    task automatic flush();
        pend      = 4'b0000;
        out_ready = 1'b1;
        repeat (2) cycle();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b0;
        pend      = 4'b1111;
        for (int i = 0; i < 4; i++) d[i] = 16'h0;
        #2;
        checks++;
        if ({out_valid, out_data, out_sel, in_ready} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v%b d%h s%0d r%b expected all zero",
                     out_valid, out_data, out_sel, in_ready);
        end
        @(posedge clk);
        #1;
        rst  = 1'b0;
        pend = 4'b0000;
        repeat (3) cycle();
        checks++;
        if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle: got in_ready %b out_valid %b expected 0000 0", in_ready, out_valid);
        end
        $display("reset/idle done");
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        d[2]      = 16'hA5A5;
        pend      = 4'b0100;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b expected 0100", in_ready);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hA5A5 || out_sel !== 2'd2) begin
            errors++;
            $display("FAIL single_out: got v%b d%h s%0d expected v1 dA5A5 s2",
                     out_valid, out_data, out_sel);
        end
        $display("single transfer ch2 A5A5");
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        d[0]      = 16'h1234;
        pend      = 4'b0001;
        cycle();
        out_ready = 1'b0;
        d[0]      = 16'h5678;
        pend      = 4'b0001;
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000 || out_data !== 16'h1234 || out_sel !== 2'd0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_%0d: got r%b v%b d%h s%0d expected r0000 v1 d1234 s0",
                         n, in_ready, out_valid, out_data, out_sel);
            end
            cycle();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL stall_release_ready: got %b expected 0001", in_ready);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h5678) begin
            errors++;
            $display("FAIL stall_reload: got v%b d%h expected v1 d5678", out_valid, out_data);
        end
        flush();
        $display("stall of 5 cycles done");
    endtask

    // Every channel in mask held valid continuously; fresh data after each grant.
    task automatic test_continuous(input logic [3:0] mask, input int n);
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (mask[c] && !pend[c]) begin
                    pend[c] = 1'b1;
                    d[c]    = 16'($urandom);
                end
            end
            cycle();
        end
        flush();
        $display("continuous requests mask %b done", mask);
    endtask

    task automatic test_all_valid_order();
        int start;
        int exp_sel;
        start     = m_ptr;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (!pend[c]) begin
                    pend[c] = 1'b1;
                    d[c]    = 16'(16'h1000 * c + k);
                end
            end
            cycle();
`ifdef DATA_PATH_ARBITER_RR_EN
            exp_sel = (start + k) % 4;
`else
            exp_sel = 0;
`endif
            checks++;
            if (out_sel !== 2'(exp_sel)) begin
                errors++;
                $display("FAIL order_%0d: got sel %0d expected %0d", k, out_sel, exp_sel);
            end
        end
        flush();
        $display("all-valid order done");
    endtask

    task automatic test_random(input int n);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (!pend[c] && $urandom_range(0, 2) == 0) begin
                    pend[c] = 1'b1;
                    d[c]    = 16'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        out_ready = 1'b1;
        while (pend != 4'b0000) cycle();
        flush();
        $display("random traffic %0d cycles done", n);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        d[3]      = 16'hBEEF;
        pend      = 4'b1000;
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd3) begin
            errors++;
            $display("FAIL mid_full: got v%b s%0d expected v1 s3", out_valid, out_sel);
        end
        pend = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sel !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: got v%b d%h s%0d expected v0 d0000 s0",
                     out_valid, out_data, out_sel);
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_valid = 1'b0;
        m_ptr   = 0;
        q.delete();
        out_ready = 1'b1;
        pend      = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_first_grant: got %b expected 0001", in_ready);
        end
        test_continuous(4'b1111, 4);
        $display("reset mid-stream done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_all_valid_order();
        test_continuous(4'b1111, 8);
        test_continuous(4'b1010, 8);
        test_random(200);
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
